// File: rtl/jtag_unlock_pkg.sv
// rtl/jtag_unlock_pkg.sv - shared state encoding and default parameters for the JTAG unlock controller
package jtag_unlock_pkg;

   localparam int KEY_W_DEF       = 32;
   localparam int MAX_FAIL_DEF    = 3;
   localparam int LOCKOUT_CYC_DEF = 1024;

   typedef enum logic [1:0] {
      ST_LOCKED   = 2'd0,
      ST_CHECK    = 2'd1,
      ST_UNLOCKED = 2'd2,
      ST_LOCKOUT  = 2'd3
   } unlock_state_e;

endpackage

// File: rtl/lockout_timer.sv
// rtl/lockout_timer.sv - loadable down-counter that holds at zero and flags expiry
module lockout_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/jtag_unlock_ctrl.sv
// rtl/jtag_unlock_ctrl.sv - debug unlock FSM: key check against fuses, fail counting, timed lockout
module jtag_unlock_ctrl
   import jtag_unlock_pkg::*;
#(
   parameter int KEY_W       = KEY_W_DEF,
   parameter int MAX_FAIL    = MAX_FAIL_DEF,
   parameter int LOCKOUT_CYC = LOCKOUT_CYC_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [KEY_W-1:0]              fuse_key,
   input  logic                          fuse_valid,
   input  logic                          key_valid,
   input  logic [KEY_W-1:0]              key_data,
   output logic                          key_ready,
   input  logic                          relock_req,
   output logic                          debug_unlocked,
   output logic                          lock_update,
   output logic [$clog2(MAX_FAIL+1)-1:0] fail_count,
   output logic                          lockout
);

   localparam int FW = $clog2(MAX_FAIL + 1);
   localparam int TW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
   localparam logic [FW-1:0] MAX_F    = FW'(MAX_FAIL);
   localparam logic [TW-1:0] TMR_LOAD = TW'(LOCKOUT_CYC - 1);

   unlock_state_e    state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [FW-1:0]    fail_q, fail_d;
   logic             unlocked_q, unlocked_d;
   logic             update_q, update_d;
   logic [FW-1:0]    fail_inc;
   logic             key_match;
   logic             tmr_load;
   logic             tmr_expired;

   assign key_match = fuse_valid && (key_q == fuse_key);
   assign fail_inc  = (fail_q == MAX_F) ? MAX_F : fail_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      key_d      = key_q;
      fail_d     = fail_q;
      unlocked_d = unlocked_q;
      update_d   = 1'b0;
      tmr_load   = 1'b0;
      case (state_q)
         ST_LOCKED: begin
            if (key_valid) begin
               key_d   = key_data;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            // The attempted key is not retained once it has been judged.
            key_d = '0;
            if (key_match) begin
               state_d    = ST_UNLOCKED;
               unlocked_d = 1'b1;
               update_d   = 1'b1;
               fail_d     = '0;
            end else begin
               fail_d = fail_inc;
               if (fail_inc == MAX_F) begin
                  state_d  = ST_LOCKOUT;
                  tmr_load = 1'b1;
               end else begin
                  state_d = ST_LOCKED;
               end
            end
         end
         ST_UNLOCKED: begin
            // Wait out the grant strobe so lock_update never fires back to back.
            if ((relock_req || !fuse_valid) && !update_q) begin
               state_d    = ST_LOCKED;
               unlocked_d = 1'b0;
               update_d   = 1'b1;
            end
         end
         ST_LOCKOUT: begin
            if (tmr_expired) begin
               state_d = ST_LOCKED;
               fail_d  = MAX_F - 1'b1;
            end
         end
         default: state_d = ST_LOCKED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_LOCKED;
         key_q      <= '0;
         fail_q     <= '0;
         unlocked_q <= 1'b0;
         update_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         key_q      <= key_d;
         fail_q     <= fail_d;
         unlocked_q <= unlocked_d;
         update_q   <= update_d;
      end
   end

   lockout_timer #(
      .W(TW)
   ) u_lockout_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (TMR_LOAD),
      .expired  (tmr_expired)
   );

   assign key_ready      = (state_q == ST_LOCKED);
   assign lockout        = (state_q == ST_LOCKOUT);
   assign debug_unlocked = unlocked_q;
   assign lock_update    = update_q;
   assign fail_count     = fail_q;

endmodule

// File: tb/tb_jtag_unlock_ctrl.sv
// tb/tb_jtag_unlock_ctrl.sv - directed self-checking bench for jtag_unlock_ctrl
module tb_jtag_unlock_ctrl;

   localparam logic [31:0] FUSE = 32'hA5A5_1234;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] fuse_key;
   logic        fuse_valid;
   logic        key_valid;
   logic [31:0] key_data;
   logic        key_ready;
   logic        relock_req;
   logic        debug_unlocked;
   logic        lock_update;
   logic [1:0]  fail_count;
   logic        lockout;

   int n_chk  = 0;
   int n_pass = 0;

   jtag_unlock_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .fuse_key       (fuse_key),
      .fuse_valid     (fuse_valid),
      .key_valid      (key_valid),
      .key_data       (key_data),
      .key_ready      (key_ready),
      .relock_req     (relock_req),
      .debug_unlocked (debug_unlocked),
      .lock_update    (lock_update),
      .fail_count     (fail_count),
      .lockout        (lockout)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   // Leaves the bench at the sample point of the CHECK cycle.
   task automatic offer(input logic [31:0] k);
      key_data  = k;
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      key_data  = '0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      step();
      n_chk++; if (lock_update !== 1'b1) $display("FAIL reset_lu: got %0d want 1", lock_update); else n_pass++;
      n_chk++; if (debug_unlocked !== 1'b0) $display("FAIL reset_du: got %0d want 0", debug_unlocked); else n_pass++;
      n_chk++; if (fail_count !== 2'd0) $display("FAIL reset_fc: got %0d want 0", fail_count); else n_pass++;
      n_chk++; if (lockout !== 1'b0) $display("FAIL reset_lo: got %0d want 0", lockout); else n_pass++;
      reset = 1'b0;
      step();
      n_chk++; if (lock_update !== 1'b0) $display("FAIL post_reset_lu: got %0d want 0", lock_update); else n_pass++;
      n_chk++; if (key_ready !== 1'b1) $display("FAIL post_reset_kr: got %0d want 1", key_ready); else n_pass++;
   endtask

   task automatic test_unlock;
      offer(FUSE);
      n_chk++; if (key_ready !== 1'b0) $display("FAIL unlock_c1_kr: got %0d want 0", key_ready); else n_pass++;
      n_chk++; if (lock_update !== 1'b0) $display("FAIL unlock_c1_lu: got %0d want 0", lock_update); else n_pass++;
      n_chk++; if (debug_unlocked !== 1'b0) $display("FAIL unlock_c1_du: got %0d want 0", debug_unlocked); else n_pass++;
      step();
      n_chk++; if (lock_update !== 1'b1) $display("FAIL unlock_c2_lu: got %0d want 1", lock_update); else n_pass++;
      n_chk++; if (debug_unlocked !== 1'b1) $display("FAIL unlock_c2_du: got %0d want 1", debug_unlocked); else n_pass++;
      n_chk++; if (fail_count !== 2'd0) $display("FAIL unlock_c2_fc: got %0d want 0", fail_count); else n_pass++;
      step();
      n_chk++; if (lock_update !== 1'b0) $display("FAIL unlock_c3_lu: got %0d want 0", lock_update); else n_pass++;
      n_chk++; if (debug_unlocked !== 1'b1) $display("FAIL unlock_c3_du: got %0d want 1", debug_unlocked); else n_pass++;
   endtask

   task automatic test_relock_both;
      int strobes = 0;
      relock_req = 1'b1;
      fuse_valid = 1'b0;
      step();
      relock_req = 1'b0;
      n_chk++; if (lock_update !== 1'b1) $display("FAIL relock_lu: got %0d want 1", lock_update); else n_pass++;
      n_chk++; if (debug_unlocked !== 1'b0) $display("FAIL relock_du: got %0d want 0", debug_unlocked); else n_pass++;
      n_chk++; if (key_ready !== 1'b1) $display("FAIL relock_kr: got %0d want 1", key_ready); else n_pass++;
      repeat (3) begin
         step();
         if (lock_update) strobes++;
      end
      n_chk++; if (strobes !== 0) $display("FAIL relock_extra_strobes: got %0d want 0", strobes); else n_pass++;
      fuse_valid = 1'b1;
   endtask

   task automatic test_relock_ignored;
      int strobes = 0;
      relock_req = 1'b1;
      repeat (3) begin
         step();
         if (lock_update) strobes++;
      end
      relock_req = 1'b0;
      n_chk++; if (strobes !== 0) $display("FAIL relock_ignored_strobes: got %0d want 0", strobes); else n_pass++;
      n_chk++; if (debug_unlocked !== 1'b0) $display("FAIL relock_ignored_du: got %0d want 0", debug_unlocked); else n_pass++;
   endtask

   task automatic test_fuse_invalid;
      fuse_valid = 1'b0;
      offer(FUSE);
      step();
      n_chk++; if (fail_count !== 2'd1) $display("FAIL nofuse_fc: got %0d want 1", fail_count); else n_pass++;
      n_chk++; if (debug_unlocked !== 1'b0) $display("FAIL nofuse_du: got %0d want 0", debug_unlocked); else n_pass++;
      n_chk++; if (lock_update !== 1'b0) $display("FAIL nofuse_lu: got %0d want 0", lock_update); else n_pass++;
      n_chk++; if (key_ready !== 1'b1) $display("FAIL nofuse_kr: got %0d want 1", key_ready); else n_pass++;
      fuse_valid = 1'b1;
   endtask

   task automatic test_back_to_back;
      offer(FUSE);
      step();
      relock_req = 1'b1;
      step();
      n_chk++; if (lock_update !== 1'b0) $display("FAIL b2b_gap_lu: got %0d want 0", lock_update); else n_pass++;
      n_chk++; if (debug_unlocked !== 1'b1) $display("FAIL b2b_gap_du: got %0d want 1", debug_unlocked); else n_pass++;
      step();
      relock_req = 1'b0;
      n_chk++; if (lock_update !== 1'b1) $display("FAIL b2b_relock_lu: got %0d want 1", lock_update); else n_pass++;
      n_chk++; if (debug_unlocked !== 1'b0) $display("FAIL b2b_relock_du: got %0d want 0", debug_unlocked); else n_pass++;
      step();
      n_chk++; if (lock_update !== 1'b0) $display("FAIL b2b_after_lu: got %0d want 0", lock_update); else n_pass++;
   endtask

   task automatic test_lockout;
      logic [31:0] wrong [3];
      int cyc;
      logic bad;
      wrong[0] = FUSE ^ 32'h0000_0001;
      wrong[1] = FUSE ^ 32'h8000_0000;
      wrong[2] = 32'h0000_0000;
      for (int i = 0; i < 3; i++) begin
         offer(wrong[i]);
         step();
         n_chk++; if (fail_count !== 2'(i + 1)) $display("FAIL lockout_fc%0d: got %0d want %0d", i, fail_count, i + 1); else n_pass++;
         n_chk++; if (debug_unlocked !== 1'b0) $display("FAIL lockout_du%0d: got %0d want 0", i, debug_unlocked); else n_pass++;
      end
      n_chk++; if (lockout !== 1'b1) $display("FAIL lockout_lo: got %0d want 1", lockout); else n_pass++;
      n_chk++; if (key_ready !== 1'b0) $display("FAIL lockout_kr: got %0d want 0", key_ready); else n_pass++;
      // Keep offering the right key; it must be ignored for the whole lockout.
      key_data  = FUSE;
      key_valid = 1'b1;
      cyc = 1;
      bad = 1'b0;
      while (lockout && cyc < 2000) begin
         if (key_ready || lock_update || debug_unlocked) bad = 1'b1;
         step();
         if (lockout) cyc++;
      end
      key_valid = 1'b0;
      key_data  = '0;
      n_chk++; if (cyc !== 1024) $display("FAIL lockout_len: got %0d want 1024", cyc); else n_pass++;
      n_chk++; if (bad !== 1'b0) $display("FAIL lockout_leak: got %0d want 0", bad); else n_pass++;
      n_chk++; if (fail_count !== 2'd2) $display("FAIL lockout_exit_fc: got %0d want 2", fail_count); else n_pass++;
      n_chk++; if (key_ready !== 1'b1) $display("FAIL lockout_exit_kr: got %0d want 1", key_ready); else n_pass++;
   endtask

   task automatic test_unlock_after_lockout;
      offer(FUSE);
      step();
      n_chk++; if (fail_count !== 2'd0) $display("FAIL post_lockout_fc: got %0d want 0", fail_count); else n_pass++;
      n_chk++; if (debug_unlocked !== 1'b1) $display("FAIL post_lockout_du: got %0d want 1", debug_unlocked); else n_pass++;
      n_chk++; if (lock_update !== 1'b1) $display("FAIL post_lockout_lu: got %0d want 1", lock_update); else n_pass++;
      step();
      relock_req = 1'b1;
      step();
      relock_req = 1'b0;
      step();
      n_chk++; if (debug_unlocked !== 1'b0) $display("FAIL post_lockout_relock_du: got %0d want 0", debug_unlocked); else n_pass++;
   endtask

   task automatic test_reentry;
      offer(FUSE ^ 32'h0001_0000);
      step();
      n_chk++; if (fail_count !== 2'd3) $display("FAIL reentry_fc: got %0d want 3", fail_count); else n_pass++;
      n_chk++; if (lockout !== 1'b1) $display("FAIL reentry_lo: got %0d want 1", lockout); else n_pass++;
      n_chk++; if (key_ready !== 1'b0) $display("FAIL reentry_kr: got %0d want 0", key_ready); else n_pass++;
   endtask

   task automatic test_reset_lockout;
      repeat (5) step();
      reset = 1'b1;
      step();
      n_chk++; if (lockout !== 1'b0) $display("FAIL rst_lo_lo: got %0d want 0", lockout); else n_pass++;
      n_chk++; if (fail_count !== 2'd0) $display("FAIL rst_lo_fc: got %0d want 0", fail_count); else n_pass++;
      n_chk++; if (lock_update !== 1'b1) $display("FAIL rst_lo_lu: got %0d want 1", lock_update); else n_pass++;
      n_chk++; if (debug_unlocked !== 1'b0) $display("FAIL rst_lo_du: got %0d want 0", debug_unlocked); else n_pass++;
      n_chk++; if (key_ready !== 1'b1) $display("FAIL rst_lo_kr: got %0d want 1", key_ready); else n_pass++;
      reset = 1'b0;
      step();
      n_chk++; if (lock_update !== 1'b0) $display("FAIL rst_lo_after_lu: got %0d want 0", lock_update); else n_pass++;
      n_chk++; if (lockout !== 1'b0) $display("FAIL rst_lo_after_lo: got %0d want 0", lockout); else n_pass++;
   endtask

   task automatic test_reset_check;
      offer(FUSE);
      reset = 1'b1;
      step();
      n_chk++; if (debug_unlocked !== 1'b0) $display("FAIL rst_chk_du: got %0d want 0", debug_unlocked); else n_pass++;
      n_chk++; if (lock_update !== 1'b1) $display("FAIL rst_chk_lu: got %0d want 1", lock_update); else n_pass++;
      n_chk++; if (fail_count !== 2'd0) $display("FAIL rst_chk_fc: got %0d want 0", fail_count); else n_pass++;
      reset = 1'b0;
      step();
      n_chk++; if (debug_unlocked !== 1'b0) $display("FAIL rst_chk_after_du: got %0d want 0", debug_unlocked); else n_pass++;
      n_chk++; if (lock_update !== 1'b0) $display("FAIL rst_chk_after_lu: got %0d want 0", lock_update); else n_pass++;
      step();
      n_chk++; if (debug_unlocked !== 1'b0) $display("FAIL rst_chk_late_du: got %0d want 0", debug_unlocked); else n_pass++;
   endtask

   initial begin
      reset      = 1'b1;
      fuse_key   = FUSE;
      fuse_valid = 1'b1;
      key_valid  = 1'b0;
      key_data   = '0;
      relock_req = 1'b0;
      step();
      test_reset();
      test_unlock();
      test_relock_both();
      test_relock_ignored();
      test_fuse_invalid();
      do_reset();
      test_back_to_back();
      test_lockout();
      test_unlock_after_lockout();
      test_lockout();
      test_reentry();
      test_reset_lockout();
      test_reset_check();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/jtag_unlock_ctrl.md
JTAG_UNLOCK_CTRL -- requirements
Module: jtag_unlock_ctrl

Interface
REQ-001 The block SHALL have parameter KEY_W, default 32, unlock key width in bits.
REQ-002 The block SHALL have parameter MAX_FAIL, default 3, consecutive failed attempts that trigger lockout.
REQ-003 The block SHALL have parameter LOCKOUT_CYC, default 1024, lockout duration in clk cycles.
REQ-004 The block SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port fuse_key  input  KEY_W  programmed unlock secret.
REQ-007 The block SHALL have port fuse_valid  input  1  fuse_key loaded and trustworthy.
REQ-008 The block SHALL have port key_valid  input  1  key attempt offered.
REQ-009 The block SHALL have port key_data  input  KEY_W  key attempt value.
REQ-010 The block SHALL have port key_ready  output  1  attempt can be accepted.
REQ-011 The block SHALL have port relock_req  input  1  request to re-lock debug access.
REQ-012 The block SHALL have port debug_unlocked  output  1  registered grant, drives the downstream lock register data input.
REQ-013 The block SHALL have port lock_update  output  1  one-cycle strobe, drives the downstream lock register enable.
REQ-014 The block SHALL have port fail_count  output  $clog2(MAX_FAIL+1)  consecutive failures.
REQ-015 The block SHALL have port lockout  output  1  high while in LOCKOUT.

Function
REQ-016 The FSM SHALL have states LOCKED, CHECK, UNLOCKED, LOCKOUT.
REQ-017 key_ready SHALL be high only in LOCKED; an attempt is accepted on a cycle with key_valid && key_ready, key_data registered, next state CHECK.
REQ-018 In CHECK, for one cycle, the registered key SHALL be compared to fuse_key; a match counts only if fuse_valid=1.
REQ-019 On match: next state UNLOCKED, debug_unlocked<=1, lock_update<=1 for exactly one cycle, fail_count<=0; debug_unlocked visible two cycles after the handshake cycle.
REQ-020 On mismatch: fail_count increments (saturating at MAX_FAIL); if new value = MAX_FAIL, next state LOCKOUT and timer loads LOCKOUT_CYC-1; else next state LOCKED; no lock_update.
REQ-021 In LOCKOUT, the timer SHALL decrement each cycle; key_valid is ignored; at timer=0, next state LOCKED with fail_count=MAX_FAIL-1, so one more failure re-enters LOCKOUT.
REQ-022 In UNLOCKED, relock_req=1 or fuse_valid=0 SHALL cause next state LOCKED, debug_unlocked<=0, lock_update<=1 for one cycle.
REQ-023 relock_req SHALL be ignored outside UNLOCKED; relock_req and fuse_valid drop in the same cycle SHALL produce a single relock and a single strobe.
REQ-024 lock_update SHALL never be high on two consecutive cycles; debug_unlocked SHALL change only on cycles where lock_update is asserted.
REQ-025 Key comparison SHALL be full-width equality; no partial-match information is exposed on any output.

Reset
REQ-026 While reset=1: state LOCKED, debug_unlocked=0, lock_update=1 (forces the downstream lock to a known locked value), fail_count=0, lockout=0, timer=0, captured key cleared.
REQ-027 Reset SHALL override every state, including mid-CHECK and mid-LOCKOUT; the first cycle after reset has lock_update=0 and key_ready=1.

Structure
REQ-028 State enum, KEY_W, MAX_FAIL, and LOCKOUT_CYC defaults SHALL be defined in package jtag_unlock_pkg.
REQ-029 The lockout down-counter SHALL be sub-module lockout_timer (inputs load, load_val; outputs expired).

Verification
REQ-030 Reset, then key_data=fuse_key=32'hA5A5_1234, fuse_valid=1, handshake at cycle 0 -> lock_update pulse in cycle 2, debug_unlocked=1 from cycle 2 onward.
REQ-031 Three wrong keys -> fail_count 1,2,3, lockout=1, key_ready=0 for 1024 cycles; then LOCKED with fail_count=2.
REQ-032 After REQ-031, one more wrong key -> immediate re-entry to LOCKOUT; a correct key instead -> UNLOCKED, fail_count=0.
REQ-033 UNLOCKED, relock_req=1 with fuse_valid=0 in the same cycle -> a single lock_update pulse, debug_unlocked=0, state LOCKED.
REQ-034 Correct key with fuse_valid=0 -> treated as failure, fail_count=1, debug_unlocked stays 0.
REQ-035 Reset asserted during CHECK and during LOCKOUT -> all outputs at reset values next cycle; no grant leaks.
